knight: RTL and testbench

KNIGHT -- requirements
Module: knight

---
 rtl/knight.sv | 210 +++++++++++++++++++++
 tb/tb_knight.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knight.sv
// knight: loads a 64-byte board over the master port, then writes one updated board per
// legal knight move. Define KNIGHT_MOVE_COUNT_EN to make a register 0 read return the board count.
module knight (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata,
  output logic [2:0]  o_dbg_state
);
  // Handshake: a master or slave transfer completes on a rising edge where its strobe is high
  // and its waitrequest is low; address/data stay stable while waitrequest is high.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  r_state;
  logic [31:0] r_src;
  logic [31:0] r_dst;
  logic [31:0] r_wbase;
  logic [2:0]  r_px;
  logic [2:0]  r_py;
  logic [7:0]  r_board [64];
  logic [5:0]  r_idx;
  logic        r_wait_data;
  logic [2:0]  r_mv;
  logic [5:0]  r_tgt;
`ifdef KNIGHT_MOVE_COUNT_EN
  logic [3:0]  r_count;
`endif

  logic              w_idle;
  logic [5:0]        w_src_sq;
  logic [7:0]        w_piece;
  logic signed [4:0] w_dx;
  logic signed [4:0] w_dy;
  logic signed [4:0] w_tx;
  logic signed [4:0] w_ty;
  logic              w_on_board;
  logic [5:0]        w_tgt_sq;
  logic [7:0]        w_tgt;
  logic              w_legal;
  logic              w_rd_acc;
  logic              w_rd_cap;
  logic              w_wr_acc;
  logic [7:0]        w_wbyte;
  logic              w_unused;

  assign w_idle   = (r_state == S_IDLE);
  assign w_src_sq = {r_py, r_px};
  assign w_piece  = r_board[w_src_sq];

  always_comb begin
    w_dx = 5'sd0;
    w_dy = 5'sd0;
    case (r_mv)
      3'd0: begin w_dx =  5'sd1; w_dy =  5'sd2; end
      3'd1: begin w_dx =  5'sd2; w_dy =  5'sd1; end
      3'd2: begin w_dx =  5'sd2; w_dy = -5'sd1; end
      3'd3: begin w_dx =  5'sd1; w_dy = -5'sd2; end
      3'd4: begin w_dx = -5'sd1; w_dy = -5'sd2; end
      3'd5: begin w_dx = -5'sd2; w_dy = -5'sd1; end
      3'd6: begin w_dx = -5'sd2; w_dy =  5'sd1; end
      default: begin w_dx = -5'sd1; w_dy = 5'sd2; end
    endcase
  end

  assign w_tx       = $signed({2'b00, r_px}) + w_dx;
  assign w_ty       = $signed({2'b00, r_py}) + w_dy;
  assign w_on_board = (w_tx[4:3] == 2'b00) && (w_ty[4:3] == 2'b00);
  assign w_tgt_sq   = {w_ty[2:0], w_tx[2:0]};
  assign w_tgt      = r_board[w_tgt_sq];
  // Empty target, or an enemy piece (sign bits differ) that gets captured.
  assign w_legal    = w_on_board && ((w_tgt == 8'd0) || (w_tgt[7] != w_piece[7]));

  assign w_rd_acc = master_read && !master_waitrequest;
  assign w_rd_cap = (r_state == S_LOAD) && (r_wait_data || w_rd_acc) && master_readdatavalid;
  assign w_wr_acc = master_write && !master_waitrequest;

  always_comb begin
    w_wbyte = r_board[r_idx];
    if (r_idx == w_src_sq)
      w_wbyte = 8'd0;
    else if (r_idx == r_tgt)
      w_wbyte = w_piece;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_src       <= 32'd0;
      r_dst       <= 32'd0;
      r_wbase     <= 32'd0;
      r_px        <= 3'd0;
      r_py        <= 3'd0;
      r_idx       <= 6'd0;
      r_wait_data <= 1'b0;
      r_mv        <= 3'd0;
      r_tgt       <= 6'd0;
      for (int i = 0; i < 64; i++) r_board[i] <= 8'd0;
`ifdef KNIGHT_MOVE_COUNT_EN
      r_count     <= 4'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (slave_write) begin
            case (slave_address)
              4'd0: begin
                r_state     <= S_LOAD;
                r_idx       <= 6'd0;
                r_wait_data <= 1'b0;
`ifdef KNIGHT_MOVE_COUNT_EN
                r_count     <= 4'd0;
`endif
              end
              4'd1: r_src <= slave_writedata;
              4'd2: r_dst <= slave_writedata;
              4'd3: r_px  <= slave_writedata[2:0];
              4'd4: r_py  <= slave_writedata[2:0];
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          if (w_rd_cap) begin
            r_board[r_idx] <= master_readdata[7:0];
            r_wait_data    <= 1'b0;
            r_idx          <= r_idx + 6'd1;
            if (r_idx == 6'd63) begin
              r_state <= S_SCAN;
              r_mv    <= 3'd0;
              r_wbase <= r_dst;
            end
          end else if (w_rd_acc) begin
            r_wait_data <= 1'b1;
          end
        end
        S_SCAN: begin
          if (w_piece == 8'd0) begin
            r_state <= S_DONE;
          end else if (w_legal) begin
            r_state <= S_WRITE;
            r_tgt   <= w_tgt_sq;
            r_idx   <= 6'd0;
          end else if (r_mv == 3'd7) begin
            r_state <= S_DONE;
          end else begin
            r_mv <= r_mv + 3'd1;
          end
        end
        S_WRITE: begin
          if (w_wr_acc) begin
            r_idx <= r_idx + 6'd1;
            if (r_idx == 6'd63) begin
              r_wbase <= r_wbase + 32'd64;
`ifdef KNIGHT_MOVE_COUNT_EN
              r_count <= r_count + 4'd1;
`endif
              if (r_mv == 3'd7) begin
                r_state <= S_DONE;
              end else begin
                r_state <= S_SCAN;
                r_mv    <= r_mv + 3'd1;
              end
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are gated by rst so strobes drop in the very cycle reset is applied.
  assign slave_waitrequest = !rst && !w_idle;
  assign master_read       = !rst && (r_state == S_LOAD) && !r_wait_data;
  assign master_write      = !rst && (r_state == S_WRITE);
  assign master_writedata  = {24'd0, w_wbyte};
  assign o_dbg_state       = r_state;

  always_comb begin
    master_address = 32'd0;
    if (!rst && r_state == S_LOAD)
      master_address = r_src + {26'd0, r_idx};
    else if (!rst && r_state == S_WRITE)
      master_address = r_wbase + {26'd0, r_idx};
  end

`ifdef KNIGHT_MOVE_COUNT_EN
  assign slave_readdata = (!rst && w_idle && slave_read && slave_address == 4'd0) ?
                          {28'd0, r_count} : 32'd0;
`else
  assign slave_readdata = 32'd0;
`endif

  assign w_unused = ^{master_readdata[31:8], slave_read};
endmodule

// File: tb/tb_knight.sv
// tb_knight: randomized and directed runs of knight against a board-level move model,
// with a memory responder that can insert wait states and delayed read data.
module tb_knight;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slave_waitrequest;
  logic [3:0]  slave_address = 4'd0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = 32'd0;
  logic        master_waitrequest = 1'b0;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata = 32'd0;
  logic        master_readdatavalid = 1'b0;
  logic        master_write;
  logic [31:0] master_writedata;
  logic [2:0]  o_dbg_state;

  localparam int LIMIT = 20000;

  int total = 0;
  int bad = 0;

  logic [7:0]  mem [0:4095];
  logic [7:0]  brd [64];
  logic [63:0] exp_q [$];
  logic [63:0] obs_q [$];

  bit rand_wait = 1'b0;
  int pend_cnt = 0;
  logic [11:0] pend_addr = 12'd0;
  int rd_n = 0;
  int rd_err = 0;
  int both_err = 0;
  int src_exp = 0;
  int resp_d;

  knight dut (
    .clk(clk), .rst(rst),
    .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
    .slave_read(slave_read), .slave_readdata(slave_readdata),
    .slave_write(slave_write), .slave_writedata(slave_writedata),
    .master_waitrequest(master_waitrequest), .master_address(master_address),
    .master_read(master_read), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid),
    .master_write(master_write), .master_writedata(master_writedata),
    .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory responder: inputs are set on the falling edge for the following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      pend_cnt = 0;
      master_readdatavalid = 1'b0;
      master_waitrequest = 1'b0;
    end else begin
      master_waitrequest = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
      master_readdatavalid = 1'b0;
      if (master_read && master_write) both_err++;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          master_readdatavalid = 1'b1;
          master_readdata = {24'hABCDEF, mem[pend_addr]};
        end
      end
      if (master_read && !master_waitrequest) begin
        if (master_address != 32'(src_exp + rd_n)) rd_err++;
        rd_n++;
        resp_d = rand_wait ? $urandom_range(1, 3) : 0;
        if (resp_d == 0) begin
          master_readdatavalid = 1'b1;
          master_readdata = {24'h5A5A5A, mem[master_address[11:0]]};
        end else begin
          pend_cnt = resp_d;
          pend_addr = master_address[11:0];
        end
      end
      if (master_write && !master_waitrequest) begin
        obs_q.push_back({master_address, master_writedata});
        mem[master_address[11:0]] = master_writedata[7:0];
      end
    end
  end

  task automatic sl_write(input logic [3:0] a, input logic [31:0] d, output int waited);
    int n;
    @(posedge clk); #1;
    slave_address = a;
    slave_writedata = d;
    slave_write = 1'b1;
    n = 0;
    @(negedge clk);
    while (slave_waitrequest && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("sw_bound", 64'(n < LIMIT), 64'd1);
    @(posedge clk); #1;
    slave_write = 1'b0;
    waited = n;
  endtask

  task automatic sl_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    @(posedge clk); #1;
    slave_address = a;
    slave_read = 1'b1;
    n = 0;
    @(negedge clk);
    while (slave_waitrequest && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("sr_bound", 64'(n < LIMIT), 64'd1);
    d = slave_readdata;
    @(posedge clk); #1;
    slave_read = 1'b0;
  endtask

  // Reference: enumerate knight jumps in the required order and emit whole boards.
  task automatic build_expected(input int x, input int y, input int dst, output int nb);
    int dxs[8];
    int dys[8];
    int tx, ty;
    logic signed [7:0] p, t, b;
    dxs = '{1, 2, 2, 1, -1, -2, -2, -1};
    dys = '{2, 1, -1, -2, -2, -1, 1, 2};
    exp_q.delete();
    nb = 0;
    p = brd[y * 8 + x];
    if (p == 0) return;
    for (int m = 0; m < 8; m++) begin
      tx = x + dxs[m];
      ty = y + dys[m];
      if (tx < 0 || tx > 7 || ty < 0 || ty > 7) continue;
      t = brd[ty * 8 + tx];
      if (t != 0 && ((t < 0) == (p < 0))) continue;
      for (int i = 0; i < 64; i++) begin
        b = brd[i];
        if (i == y * 8 + x) b = 0;
        if (i == ty * 8 + tx) b = p;
        exp_q.push_back({32'(dst + nb * 64 + i), 24'd0, b});
      end
      nb++;
    end
  endtask

  task automatic run_case(input string nm, input int src, input int dst, input int x, input int y,
                          input bit skip_x, input bit late_en, input int late_x);
    int nb, w;
    logic [31:0] rd;
    for (int i = 0; i < 64; i++) mem[src + i] = brd[i];
    build_expected(x, y, dst, nb);
    obs_q.delete();
    rd_n = 0;
    rd_err = 0;
    both_err = 0;
    src_exp = src;
    sl_write(4'd1, 32'(src), w);
    sl_write(4'd2, 32'(dst), w);
    if (!skip_x) sl_write(4'd3, 32'(x), w);
    sl_write(4'd4, 32'(y), w);
    sl_write(4'd0, 32'hDEAD_BEEF, w);
    @(negedge clk);
    check({nm, ":busy"}, 64'(slave_waitrequest), 64'd1);
    if (late_en) begin
      sl_write(4'd3, 32'(late_x), w);
      check({nm, ":late_stall"}, 64'(w > 64), 64'd1);
    end
    sl_read(4'd0, rd);
`ifdef KNIGHT_MOVE_COUNT_EN
    check({nm, ":count"}, 64'(rd), 64'(nb));
`else
    check({nm, ":reg0"}, 64'(rd), 64'd0);
`endif
    check({nm, ":nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s:wr%0d", nm, i), obs_q[i], exp_q[i]);
    check({nm, ":nrd"}, 64'(rd_n), 64'd64);
    check({nm, ":rd_order"}, 64'(rd_err), 64'd0);
    check({nm, ":rw_excl"}, 64'(both_err), 64'd0);
  endtask

  task automatic clear_brd();
    for (int i = 0; i < 64; i++) brd[i] = 8'd0;
  endtask

  task automatic rand_brd();
    for (int i = 0; i < 64; i++)
      brd[i] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(0, 56) - 28);
  endtask

  initial begin
    int w, n, x, y, src, dst;
    logic [31:0] rd;
    for (int i = 0; i < 4096; i++) mem[i] = 8'd0;
    clear_brd();
    slave_read = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst:waitreq", 64'(slave_waitrequest), 64'd0);
    check("rst:mread", 64'(master_read), 64'd0);
    check("rst:mwrite", 64'(master_write), 64'd0);
    check("rst:maddr", 64'(master_address), 64'd0);
    check("rst:state", 64'(o_dbg_state), 64'd0);
    check("rst:reg0", 64'(slave_readdata), 64'd0);
    @(posedge clk); #1;
    slave_read = 1'b0;
    rst = 1'b0;

    brd[0] = 8'd19;
    run_case("corner", 0, 0, 0, 0, 1'b0, 1'b0, 0);

    clear_brd();
    brd[27] = 8'd19;
    run_case("center", 0, 512, 3, 3, 1'b0, 1'b1, 0);

    clear_brd();
    brd[0] = 8'd19;
    brd[17] = 8'd1;
    brd[10] = 8'hFF;
    run_case("capture", 64, 1024, 0, 0, 1'b1, 1'b0, 0);

    rand_brd();
    brd[5 * 8 + 2] = 8'd0;
    run_case("empty", 128, 1024, 2, 5, 1'b0, 1'b0, 0);

    rand_wait = 1'b1;
    clear_brd();
    brd[0] = 8'd19;
    run_case("corner_wait", 0, 0, 0, 0, 1'b0, 1'b0, 0);
    rand_wait = 1'b0;

    // Reset while writing boards.
    clear_brd();
    brd[27] = 8'hEC;
    for (int i = 0; i < 64; i++) mem[i] = brd[i];
    sl_write(4'd1, 32'd0, w);
    sl_write(4'd2, 32'd1024, w);
    sl_write(4'd3, 32'd3, w);
    sl_write(4'd4, 32'd3, w);
    sl_write(4'd0, 32'd0, w);
    n = 0;
    @(negedge clk);
    while (!master_write && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort:reached_write", 64'(master_write), 64'd1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort:mwrite", 64'(master_write), 64'd0);
    check("abort:mread", 64'(master_read), 64'd0);
    check("abort:waitreq", 64'(slave_waitrequest), 64'd0);
    check("abort:maddr", 64'(master_address), 64'd0);
    @(negedge clk);
    check("abort:state", 64'(o_dbg_state), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sl_read(4'd0, rd);
    check("abort:reg0", 64'(rd), 64'd0);
    clear_brd();
    brd[0] = 8'd19;
    run_case("after_rst", 0, 0, 0, 0, 1'b0, 1'b0, 0);

    for (int r = 0; r < 10; r++) begin
      rand_wait = $urandom_range(0, 1);
      rand_brd();
      x = $urandom_range(0, 7);
      y = $urandom_range(0, 7);
      brd[y * 8 + x] = 8'($urandom_range(19, 28));
      if ($urandom_range(0, 1) == 1) brd[y * 8 + x] = -brd[y * 8 + x];
      src = 64 * $urandom_range(0, 15);
      dst = 1024 + 64 * $urandom_range(0, 32);
      run_case($sformatf("rand%0d", r), src, dst, x, y, 1'b0, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
